// File: rtl/rgb_status_indicator_if.sv
// Bundle between the frequency classifier / board control and the RGB status LED driver.
// state_valid is a one-cycle strobe with no ready: the indicator accepts every sample.
interface rgb_status_indicator_if #(
    parameter int STATE_W = 4,
    parameter int PWM_W   = 8
);
    logic [STATE_W-1:0] freq_state;
    logic               state_valid;
    logic [PWM_W-1:0]   brightness;
    logic               solid_mode;
    logic               red;
    logic               green;
    logic               blue;
    logic [STATE_W-1:0] active_code;
    logic [1:0]         dbg_state;

    modport master (
        output freq_state, state_valid, brightness, solid_mode,
        input  red, green, blue, active_code, dbg_state
    );

    modport slave (
        input  freq_state, state_valid, brightness, solid_mode,
        output red, green, blue, active_code, dbg_state
    );
endinterface

// File: rtl/rgb_status_indicator.sv
// Maps classifier codes to a colour on a common RGB LED with blink, PWM brightness
// and a minimum display hold so short detections remain visible.
module rgb_status_indicator #(
    parameter int STATE_W    = 4,
    parameter int CODE_BLUE  = 9,
    parameter int CODE_RED   = 10,
    parameter int CODE_GREEN = 11,
    parameter int BLINK_DIV  = 33554432,
    parameter int HOLD_TICKS = 4,
    parameter int PWM_W      = 8
) (
    input logic               clk,
    input logic               rst,
    rgb_status_indicator_if.slave bus
);
    localparam int PRESC_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_FOLLOW = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [STATE_W-1:0] code_q, code_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               phase_q, phase_d;
    logic               pend_vld_q, pend_vld_d;
    logic [STATE_W-1:0] pend_code_q, pend_code_d;
    logic [PWM_W-1:0]   pwm_q;
    logic               red_q, green_q, blue_q;
    logic               red_d, green_d, blue_d;

    logic               cand_vld;
    logic [STATE_W-1:0] cand_code;
    logic               cand_rec;
    logic               tick;
    logic               relatch;

    // A live sample takes priority over the one parked during HOLD.
    assign cand_vld  = bus.state_valid | pend_vld_q;
    assign cand_code = bus.state_valid ? bus.freq_state : pend_code_q;
    assign cand_rec  = (cand_code == STATE_W'(CODE_BLUE)) ||
                       (cand_code == STATE_W'(CODE_RED))  ||
                       (cand_code == STATE_W'(CODE_GREEN));
    assign tick      = (presc_q == PRESC_W'(BLINK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            presc_q     <= '0;
            hold_q      <= '0;
            phase_q     <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_code_q <= '0;
            pwm_q       <= '0;
            red_q       <= 1'b0;
            green_q     <= 1'b0;
            blue_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            presc_q     <= presc_d;
            hold_q      <= hold_d;
            phase_q     <= phase_d;
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
            pwm_q       <= pwm_q + PWM_W'(1);
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        presc_d     = tick ? '0 : presc_q + PRESC_W'(1);
        phase_d     = phase_q ^ tick;
        hold_d      = hold_q;
        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        relatch     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pend_vld_d = 1'b0;
                if (cand_vld && cand_rec) begin
                    relatch = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.state_valid) begin
                    pend_code_d = bus.freq_state;
                    pend_vld_d  = 1'b1;
                end
                if (tick) begin
                    if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                        state_d = ST_FOLLOW;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            ST_FOLLOW: begin
                pend_vld_d = 1'b0;
                if (cand_vld) begin
                    if (!cand_rec) begin
                        state_d = ST_IDLE;
                        code_d  = '0;
                    end else if (cand_code != code_q) begin
                        relatch = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                code_d  = '0;
            end
        endcase
        // A fresh code restarts the blink so it always begins in the lit phase.
        if (relatch) begin
            code_d  = cand_code;
            presc_d = '0;
            hold_d  = '0;
            phase_d = 1'b1;
        end
    end

    logic shown;
    logic lit;
    logic pwm_on;

    always_comb begin
        shown   = (state_q != ST_IDLE);
        lit     = bus.solid_mode | phase_q;
        pwm_on  = (&bus.brightness) | (pwm_q < bus.brightness);
        red_d   = shown && lit && pwm_on && (code_q == STATE_W'(CODE_RED));
        green_d = shown && lit && pwm_on && (code_q == STATE_W'(CODE_GREEN));
        blue_d  = shown && lit && pwm_on && (code_q == STATE_W'(CODE_BLUE));
    end

    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.active_code = code_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_rgb_status_indicator.sv
// Self-checking bench for rgb_status_indicator using a time-based model of blink,
// hold and PWM behaviour.
module tb_rgb_status_indicator;
    localparam int DIV = 4;
    localparam int HT  = 2;
    localparam int PW  = 4;
    localparam int SW  = 4;
    localparam int M_IDLE = 0, M_HOLD = 1, M_FOLLOW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rgb_status_indicator_if #(.STATE_W(SW), .PWM_W(PW)) bus ();

    rgb_status_indicator #(
        .STATE_W(SW), .CODE_BLUE(9), .CODE_RED(10), .CODE_GREEN(11),
        .BLINK_DIV(DIV), .HOLD_TICKS(HT), .PWM_W(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // model: display start cycle, latched code, pending sample, cycles since reset
    int          m_mode;
    logic [3:0]  m_code;
    int          m_start;
    bit          m_pv;
    logic [3:0]  m_pc;
    int          cyc;
    logic [6:0]  exp_q[$];
    logic [6:0]  exp_v;

    function automatic logic [2:0] onehot(logic [3:0] c);
        case (c)
            4'd10:   return 3'b100;
            4'd11:   return 3'b010;
            4'd9:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit is_rec(logic [3:0] c);
        return (c == 4'd9) || (c == 4'd10) || (c == 4'd11);
    endfunction

    function automatic logic [6:0] observed();
        return {bus.red, bus.green, bus.blue, bus.active_code};
    endfunction

    task automatic model_clear();
        m_mode = M_IDLE; m_code = '0; m_start = 0; m_pv = 0; m_pc = '0; cyc = 0;
        exp_q.delete();
    endtask

    task automatic drive(bit v, logic [3:0] c);
        bus.state_valid = v;
        bus.freq_state  = c;
    endtask

    // Advance one clock; the model predicts what the registered outputs show afterwards.
    task automatic cycle();
        int k;
        bit lit, pwm, cv;
        logic [3:0] cc;
        logic [2:0] nrgb;
        k    = cyc - m_start;
        lit  = bus.solid_mode || (((k / DIV) % 2) == 0);
        pwm  = (bus.brightness == 4'hF) || ((cyc % (1 << PW)) < int'(bus.brightness));
        nrgb = (m_mode != M_IDLE && lit && pwm) ? onehot(m_code) : 3'b000;
        cv   = bus.state_valid || m_pv;
        cc   = bus.state_valid ? bus.freq_state : m_pc;
        if (m_mode == M_HOLD) begin
            if (bus.state_valid) begin
                m_pv = 1; m_pc = bus.freq_state;
            end
            if (k == HT * DIV - 1) m_mode = M_FOLLOW;
        end else begin
            m_pv = 0;
            if (cv && is_rec(cc) && (m_mode == M_IDLE || cc != m_code)) begin
                m_mode = M_HOLD; m_code = cc; m_start = cyc + 1;
            end else if (cv && !is_rec(cc) && m_mode == M_FOLLOW) begin
                m_mode = M_IDLE; m_code = '0;
            end
        end
        exp_q.push_back({nrgb, m_code});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        bus.brightness = 4'hF; bus.solid_mode = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (observed() !== 7'd0 || exp_v !== 7'd0) begin
                n_fail++;
                $display("FAIL reset_idle i=%0d got=%b exp=%b", i, observed(), 7'd0);
            end
        end
        n_cmp++;
        if (bus.dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%0d exp=0", bus.dbg_state);
        end
    endtask

    task automatic test_basic();
        do_reset();
        drive(1, 4'd10);
        for (int j = 1; j <= 24; j++) begin
            cycle();
            drive(0, '0);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (observed() !== exp_v) begin
                n_fail++;
                $display("FAIL basic_model cyc=%0d got=%b exp=%b", j, observed(), exp_v);
            end
            if (j == 1 || j == 2 || j == 6 || j == 10) begin
                n_cmp++;
                if (bus.red !== ((j == 2 || j == 10) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL basic_red_edge cyc=%0d got=%b", j, bus.red);
                end
            end
            if (j == 8 || j == 9) begin
                n_cmp++;
                if (bus.dbg_state !== ((j == 9) ? 2'd2 : 2'd1)) begin
                    n_fail++;
                    $display("FAIL basic_follow cyc=%0d got=%0d", j, bus.dbg_state);
                end
            end
        end
    endtask

    task automatic test_pending();
        bit saw_green = 0;
        do_reset();
        drive(1, 4'd10);
        for (int j = 1; j <= 24; j++) begin
            cycle();
            if (j == 1) drive(1, 4'd11);
            else if (j == 2) drive(1, 4'd9);
            else drive(0, '0);
            exp_v = exp_q.pop_front();
            if (bus.green === 1'b1 || bus.active_code === 4'd11) saw_green = 1;
            n_cmp++;
            if (observed() !== exp_v) begin
                n_fail++;
                $display("FAIL pending_model cyc=%0d got=%b exp=%b", j, observed(), exp_v);
            end
        end
        n_cmp++;
        if (saw_green || bus.active_code !== 4'd9) begin
            n_fail++;
            $display("FAIL pending_last got=%0d green_seen=%0d exp=9", bus.active_code, saw_green);
        end
    endtask

    task automatic test_follow();
        int guard = 0;
        // continues from the blue display left by test_pending
        while (bus.dbg_state !== 2'd2 && guard < 40) begin
            cycle();
            exp_v = exp_q.pop_front();
            guard++;
        end
        n_cmp++;
        if (bus.dbg_state !== 2'd2) begin
            n_fail++;
            $display("FAIL follow_wait got=%0d exp=2", bus.dbg_state);
        end
        for (int j = 0; j < 16; j++) begin
            drive((j % 3) == 0, 4'd9);
            cycle();
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (observed() !== exp_v || bus.dbg_state !== 2'd2) begin
                n_fail++;
                $display("FAIL follow_same j=%0d got=%b exp=%b", j, observed(), exp_v);
            end
        end
        drive(1, 4'd5);
        cycle();
        drive(0, '0);
        cycle();
        void'(exp_q.pop_front());
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (observed() !== 7'd0 || exp_v !== 7'd0) begin
            n_fail++;
            $display("FAIL follow_unrec got=%b exp=%b", observed(), 7'd0);
        end
    endtask

    task automatic test_pwm();
        int ones = 0;
        do_reset();
        bus.solid_mode = 1; bus.brightness = 4'd4;
        drive(1, 4'd11);
        for (int j = 1; j <= 40; j++) begin
            cycle();
            drive(0, '0);
            exp_v = exp_q.pop_front();
            if (j > 8) ones += bus.green;
            n_cmp++;
            if (observed() !== exp_v) begin
                n_fail++;
                $display("FAIL pwm_model cyc=%0d got=%b exp=%b", j, observed(), exp_v);
            end
        end
        n_cmp++;
        if (ones != 8) begin
            n_fail++;
            $display("FAIL pwm_duty got=%0d exp=8", ones);
        end
        bus.brightness = 4'd0;
        ones = 0;
        for (int j = 0; j < 20; j++) begin
            cycle();
            exp_v = exp_q.pop_front();
            ones += bus.green;
        end
        n_cmp++;
        if (ones != 0) begin
            n_fail++;
            $display("FAIL pwm_zero got=%0d exp=0", ones);
        end
        bus.solid_mode = 0; bus.brightness = 4'hF;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        drive(1, 4'd10);
        repeat (3) begin
            cycle();
            drive(0, '0);
        end
        n_cmp++;
        if (bus.dbg_state !== 2'd1) begin
            n_fail++;
            $display("FAIL midhold_enter got=%0d exp=1", bus.dbg_state);
        end
        rst = 1'b1;
        drive(1, 4'd11);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, '0);
        model_clear();
        n_cmp++;
        if (observed() !== 7'd0 || bus.dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL midhold_reset got=%b st=%0d exp=0", observed(), bus.dbg_state);
        end
        for (int j = 0; j < 10; j++) begin
            cycle();
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (observed() !== 7'd0 || bus.dbg_state !== 2'd0) begin
                n_fail++;
                $display("FAIL midhold_pending j=%0d got=%b exp=0", j, observed());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] c;
        do_reset();
        for (int j = 0; j < 800; j++) begin
            if ($urandom_range(0, 39) == 0) bus.solid_mode = $urandom_range(0, 1);
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 2))
                    0: bus.brightness = 4'hF;
                    1: bus.brightness = 4'h0;
                    default: bus.brightness = 4'($urandom_range(1, 14));
                endcase
            end
            case ($urandom_range(0, 3))
                0: c = 4'd9;
                1: c = 4'd10;
                2: c = 4'd11;
                default: c = 4'($urandom_range(0, 15));
            endcase
            drive($urandom_range(0, 9) == 0, c);
            cycle();
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (observed() !== exp_v || bus.dbg_state !== 2'(m_mode)) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b st=%0d exp=%b st=%0d",
                         j, observed(), bus.dbg_state, exp_v, m_mode);
            end
            if ((32'(bus.red) + 32'(bus.green) + 32'(bus.blue)) > 1) begin
                n_cmp++;
                n_fail++;
                $display("FAIL onehot cyc=%0d got=%b%b%b", j, bus.red, bus.green, bus.blue);
            end
        end
        bus.solid_mode = 0; bus.brightness = 4'hF;
    endtask

    initial begin
        rst = 1'b1;
        bus.brightness = 4'hF;
        bus.solid_mode = 1'b0;
        drive(0, '0);
        test_reset();
        test_basic();
        test_pending();
        test_follow();
        test_pwm();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rgb_status_indicator.md
Name: rgb_status_indicator

Overview:
Parametrised successor to the single-colour frequency-state blinker. Maps detected frequency-state codes to a colour and drives a common RGB LED. Adds programmable blink rate, PWM brightness, a solid/blink mode, and a minimum-display hold so brief detections stay visible. Sits between the frequency classifier and the board RGB pins.

Parameters:
STATE_W, 4, width of freq_state / active_code
CODE_BLUE, 9, code shown as blue
CODE_RED, 10, code shown as red
CODE_GREEN, 11, code shown as green
BLINK_DIV, 33554432, clk cycles per blink tick (>=2); phase toggles each tick
HOLD_TICKS, 4, minimum blink ticks a newly accepted code is displayed (>=1)
PWM_W, 8, brightness / PWM counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
freq_state  in  STATE_W  classifier code
state_valid  in  1  freq_state sample strobe, one cycle per sample
brightness  in  PWM_W  duty: 0 = off, all-ones = fully on
solid_mode  in  1  1 = steady colour, 0 = blink
red  out  1  LED drive
green  out  1  LED drive
blue  out  1  LED drive
active_code  out  STATE_W  latched displayed code, 0 when IDLE

Behaviour:
- Reset (synchronous, rst high at clk edge): red/green/blue=0, active_code=0, state IDLE, prescaler/hold/PWM counters=0, phase=0, pending_vld=0. Reset overrides all activity, including mid-HOLD.
- Recognised code = CODE_BLUE, CODE_RED or CODE_GREEN; anything else is unrecognised.
- Candidate sample each cycle: freq_state if state_valid, else pending_code if pending_vld, else none. A live sample wins over pending.
- Pending register: in HOLD, every valid sample overwrites pending_code and sets pending_vld. It is cleared when consumed in IDLE or FOLLOW.
- Prescaler: counts 0..BLINK_DIV-1 and wraps; tick = (count==BLINK_DIV-1). Phase toggles on tick.
- FSM:
  - IDLE: colour off. Recognised candidate -> HOLD; latch code; prescaler=0, hold_cnt=0, phase=1. Unrecognised candidate is consumed; stay IDLE.
  - HOLD: display latched code; candidates are not evaluated. On tick: if hold_cnt==HOLD_TICKS-1 -> FOLLOW, else hold_cnt+1.
  - FOLLOW: display latched code.
    - Recognised candidate differing from latched code -> HOLD (relatch; restart prescaler, hold_cnt and phase=1).
    - Recognised candidate equal to latched code -> stay; phase is not disturbed.
    - Unrecognised candidate -> IDLE; active_code=0.
- Colour: one-hot per latched code (blue/red/green); at most one output ever high.
- lit = solid_mode ? 1 : phase.
- PWM: free-running PWM_W counter. pwm_on = (brightness==all-ones) | (pwm_cnt < brightness). brightness=0 gives constant off.
- Outputs are registered: colour_bit & lit & pwm_on, one cycle after internal state.
- Latency: recognised valid sample in IDLE at edge n -> HOLD at n+1 -> LED high after edge n+2 (full brightness).
- solid_mode and brightness are sampled every cycle; changes take effect on the next output register update.

Test Plan:
Params BLINK_DIV=4, HOLD_TICKS=2, PWM_W=4, brightness=15, solid_mode=0 unless stated.
- Reset, then idle 20 cycles -> all outputs 0, active_code=0.
- Valid code 10 at cycle 0 -> red=1 from cycle 2; toggles every 4 cycles; green=blue=0; active_code=10; FOLLOW after 8 cycles.
- During HOLD: valid 11 then valid 9 -> hold completes on red; then blue (last pending) is shown; 11 is never displayed.
- In FOLLOW (blue): valid 5 -> outputs 0 two cycles later, active_code=0. Repeated valid 9 in FOLLOW -> blink phase unchanged.
- solid_mode=1, code 11, brightness=4 -> green high exactly 4 of every 16 cycles. brightness=0 -> green 0 throughout.
- rst asserted mid-HOLD with state_valid high the same cycle -> next cycle all outputs 0 and IDLE; pending discarded.
